efuse_cfg_loader: RTL and testbench

//  Wishbone master that reads the FPGA bitstream out of efuse_ctrl byte by byte
//  and serialises it into the fabric configuration shift chain.
//  - Sits directly upstream of efuse_ctrl and drives its wb_* slave port.
//  - Asserts cfg_done_o when the whole image has been shifted out.

---
 rtl/efuse_cfg_loader.sv | 157 +++++++++++++++
 tb/tb_efuse_cfg_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_cfg_loader.sv
// efuse_cfg_loader
//   Wishbone read master that walks the efuse image byte by byte and
//   serialises each byte, LSB first, into the fabric configuration chain.
//
//   Ports
//     wb_clk_i     clock, everything on the rising edge
//     wb_rst_i     synchronous active-high reset
//     start_i      begin a load (accepted in IDLE/DONE/ERR only)
//     wbm_*        wishbone master port towards efuse_ctrl (read only)
//     cfg_data_o   serial configuration bit
//     cfg_shift_o  chain shift enable, one bit per high cycle
//     busy_o       load in progress (REQ or SHIFT)
//     cfg_done_o   whole image shifted, held until start_i or reset
//     err_o        ack timeout, held until start_i or reset
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for start_i after reset
//   REQ   | wishbone read outstanding, waiting for ack
//   SHIFT | eight cycles shifting the captured byte out
//   DONE  | image complete, cfg_done_o held
//   ERR   | slave did not ack in time, err_o held
module efuse_cfg_loader #(
  parameter logic [9:0] START_ADDR = 10'd0,
  parameter int         NUM_BYTES  = 1024,
  parameter int         TIMEOUT    = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start_i,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic       wbm_sel_o,
  output logic [9:0] wbm_adr_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i,
  output logic       cfg_data_o,
  output logic       cfg_shift_o,
  output logic       busy_o,
  output logic       cfg_done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SHIFT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [10:0] LAST_BYTE = 11'(NUM_BYTES - 1);
  // Leaving REQ happens on the cycle that would push the counter to TIMEOUT.
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  state_t      state;
  logic [9:0]  addr;
  logic [10:0] byte_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  tcnt;
  logic [7:0]  shift_byte;

  assign wbm_we_o = 1'b0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      addr        <= START_ADDR;
      byte_cnt    <= '0;
      bit_idx     <= '0;
      tcnt        <= '0;
      shift_byte  <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_sel_o   <= 1'b0;
      wbm_adr_o   <= '0;
      cfg_data_o  <= 1'b0;
      cfg_shift_o <= 1'b0;
      busy_o      <= 1'b0;
      cfg_done_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state      <= S_REQ;
            addr       <= START_ADDR;
            byte_cnt   <= '0;
            tcnt       <= '0;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_sel_o  <= 1'b1;
            wbm_adr_o  <= START_ADDR;
            busy_o     <= 1'b1;
            cfg_done_o <= 1'b0;
            err_o      <= 1'b0;
          end
        end

        S_REQ: begin
          if (wbm_ack_i) begin
            // Bit 0 goes out on the first SHIFT cycle, so present it now.
            state       <= S_SHIFT;
            shift_byte  <= wbm_dat_i;
            bit_idx     <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_sel_o   <= 1'b0;
            wbm_adr_o   <= '0;
            cfg_shift_o <= 1'b1;
            cfg_data_o  <= wbm_dat_i[0];
          end else if (tcnt == TO_LAST) begin
            state     <= S_ERR;
            tcnt      <= tcnt + 8'd1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= 1'b0;
            wbm_adr_o <= '0;
            busy_o    <= 1'b0;
            err_o     <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        S_SHIFT: begin
          if (bit_idx == 3'd7) begin
            cfg_shift_o <= 1'b0;
            cfg_data_o  <= 1'b0;
            if (byte_cnt == LAST_BYTE) begin
              state      <= S_DONE;
              busy_o     <= 1'b0;
              cfg_done_o <= 1'b1;
            end else begin
              // Straight back into the next read, no idle cycle.
              state     <= S_REQ;
              byte_cnt  <= byte_cnt + 11'd1;
              addr      <= addr + 10'd1;
              tcnt      <= '0;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 1'b1;
              wbm_adr_o <= addr + 10'd1;
            end
          end else begin
            bit_idx    <= bit_idx + 3'd1;
            cfg_data_o <= shift_byte[bit_idx + 3'd1];
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_cfg_loader.sv
module tb_efuse_cfg_loader;

  localparam logic [9:0] START = 10'd1022;
  localparam int         NB    = 4;
  localparam int         TO    = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ack;
  logic [7:0] dat;
  logic       cyc, stb, we, sel, cdata, cshift, busy, done, err;
  logic [9:0] adr;

  always #5 clk = ~clk;

  efuse_cfg_loader #(
    .START_ADDR(START),
    .NUM_BYTES (NB),
    .TIMEOUT   (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_i  (dat),
    .wbm_ack_i  (ack),
    .cfg_data_o (cdata),
    .cfg_shift_o(cshift),
    .busy_o     (busy),
    .cfg_done_o (done),
    .err_o      (err)
  );

  typedef struct packed {
    logic       cyc;
    logic [9:0] adr;
    logic       shift;
    logic       data;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t        trace[$];
  exp_t        rest;
  logic [7:0]  mem [1024];
  int          wait_tab [NB];
  int          n_chk = 0;
  int          n_fail = 0;

  // slave state and observation
  int          wcnt, sb, req_hi, done_at;
  bit          prev_cyc;
  logic [31:0] stream_col;
  logic [9:0]  addr_log[$];

  task automatic check(input exp_t e, input string tag);
    logic [8:0] act, ex;
    act = {cyc, stb, sel, we, cshift, cdata, busy, done, err};
    ex  = {e.cyc, e.cyc, e.cyc, 1'b0, e.shift, e.data, e.busy, e.done, e.err};
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s @%0t: {cyc,stb,sel,we,shift,data,busy,done,err} got %b expected %b",
               tag, $time, act, ex);
    end
    if (e.cyc) begin
      n_chk++;
      if (adr !== e.adr) begin
        n_fail++;
        $display("FAIL %s_adr @%0t: got %0d expected %0d", tag, $time, adr, e.adr);
      end
    end
  endtask

  task automatic check_int(input string tag, input int act, input int ex);
    n_chk++;
    if (act != ex) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, ex);
    end
  endtask

  // Expected per-cycle output sequence for one load, from the byte-level rules:
  // each byte is (waits+1) request cycles then 8 LSB-first shift cycles.
  task automatic build_trace();
    int   a;
    exp_t e;
    trace.delete();
    rest = '0;
    a = START;
    for (int k = 0; k < NB; k++) begin
      if (wait_tab[k] >= TO) begin
        for (int c = 0; c < TO; c++) begin
          e = '0; e.cyc = 1'b1; e.adr = 10'(a); e.busy = 1'b1;
          trace.push_back(e);
        end
        rest.err = 1'b1;
        return;
      end
      for (int c = 0; c <= wait_tab[k]; c++) begin
        e = '0; e.cyc = 1'b1; e.adr = 10'(a); e.busy = 1'b1;
        trace.push_back(e);
      end
      for (int b = 0; b < 8; b++) begin
        e = '0; e.shift = 1'b1; e.data = mem[a][b]; e.busy = 1'b1;
        trace.push_back(e);
      end
      a = (a + 1) % 1024;
    end
    rest.done = 1'b1;
  endtask

  task automatic observe();
    if (cyc) begin
      req_hi++;
      if (!prev_cyc) addr_log.push_back(adr);
    end
    if (cshift) stream_col = {stream_col[30:0], cdata};
    prev_cyc = cyc;
  endtask

  // Wishbone slave response for the coming edge; ack is combinational on cyc.
  task automatic slave_step(input bit stray);
    if (cyc) begin
      if (sb < NB && wcnt == wait_tab[sb]) begin
        ack  = 1'b1;
        dat  = mem[adr];
        wcnt = 0;
        sb++;
      end else begin
        ack  = 1'b0;
        dat  = 8'($urandom);
        wcnt++;
      end
    end else begin
      ack = stray && ($urandom_range(0, 2) == 0);
      dat = 8'($urandom);
    end
  endtask

  task automatic run_load(input int rst_at, input bit noise);
    bit was_rst;
    int n;
    build_trace();
    wcnt = 0; sb = 0; req_hi = 0; done_at = -1; prev_cyc = 1'b0;
    stream_col = '0; addr_log.delete(); was_rst = 1'b0;
    start = 1'b1; rst = 1'b0; ack = 1'b0; dat = 8'($urandom);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < trace.size(); i++) begin
      check(trace[i], "load");
      observe();
      slave_step(noise);
      start = 1'b0; rst = 1'b0;
      if (noise && $urandom_range(0, 4) == 0) start = 1'b1;
      if (i == rst_at) begin
        rst = 1'b1;
        start = 1'($urandom_range(0, 1));
        was_rst = 1'b1;
      end
      @(negedge clk);
      n++;
      if (was_rst) break;
    end
    if (was_rst) rest = '0;
    for (int j = 0; j < 3; j++) begin
      if (done && done_at < 0) done_at = n;
      check(rest, was_rst ? "after_reset" : "rest");
      observe();
      start = 1'b0; rst = 1'b0;
      ack = ($urandom_range(0, 1) == 0);
      dat = 8'($urandom);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    exp_t zero;
    zero = '0;
    rst = 1'b1; start = 1'b0; ack = 1'b0; dat = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    check(zero, "reset");
    start = 1'b1;
    @(negedge clk);
    check(zero, "rst_over_start");
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check(zero, "idle");

    // zero-wait slave, known data, address wrap
    mem[1022] = 8'hA5; mem[1023] = 8'h3C;
    for (int k = 0; k < NB; k++) wait_tab[k] = 0;
    run_load(-1, 1'b0);
    check_int("stream_first16", int'(stream_col[31:16]), int'(16'b1010010100111100));
    check_int("done_latency", done_at, 36);
    check_int("num_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check_int("addr0", addr_log[0], 1022);
      check_int("addr1", addr_log[1], 1023);
      check_int("addr2", addr_log[2], 0);
      check_int("addr3", addr_log[3], 1);
    end

    // five wait states on every read (one below timeout)
    for (int k = 0; k < NB; k++) wait_tab[k] = 5;
    run_load(-1, 1'b0);
    check_int("stream_waits", int'(stream_col[31:16]), int'(16'b1010010100111100));
    check_int("req_cycles_waits", req_hi, 24);

    // slave never acks
    for (int k = 0; k < NB; k++) wait_tab[k] = TO;
    run_load(-1, 1'b0);
    check_int("timeout_req_cycles", req_hi, 6);
    check_int("timeout_err", int'(err), 1);

    // timeout on the third byte
    wait_tab[0] = 0; wait_tab[1] = 3; wait_tab[2] = TO; wait_tab[3] = 0;
    run_load(-1, 1'b1);

    // reset during bit 3 of byte 0, then a clean reload
    for (int k = 0; k < NB; k++) wait_tab[k] = 0;
    run_load(4, 1'b0);
    run_load(-1, 1'b0);
    check_int("reload_stream", int'(stream_col[31:16]), int'(16'b1010010100111100));

    // start pulses while busy and stray acks outside REQ
    run_load(-1, 1'b1);
    check_int("noise_stream", int'(stream_col[31:16]), int'(16'b1010010100111100));
    check_int("noise_reads", addr_log.size(), 4);
    check_int("noise_done", done_at, 36);

    // randomized loads
    for (int r = 0; r < 30; r++) begin
      for (int i = 1020; i < 1024; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
      for (int k = 0; k < NB; k++)
        wait_tab[k] = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
      run_load(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1,
               1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
